// File: rtl/mbus_wakeup_seq.sv
// mbus_wakeup_seq: debounces the bus interrupt and steps one layer's power and isolation up or down.
module mbus_wakeup_seq #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BC_PWR_DLY   = 8,
  parameter int ISO_DLY      = 2,
  parameter int LC_PWR_DLY   = 8
) (
  input  logic CLKIN,
  input  logic RESETn,
  input  logic INT_REQ,
  input  logic SLEEP_REQ,
  output logic BC_PWR_ON,
  output logic BC_RELEASE_ISO,
  output logic LC_PWR_ON,
  output logic LC_RELEASE_ISO,
  output logic CLR_EXT_INT,
  output logic WAKE_DONE,
  output logic SEQ_BUSY
);
  typedef enum logic [3:0] {
    SLEEP, DEBOUNCE, UP_BC_PWR, UP_BC_ISO, UP_LC_PWR, UP_LC_ISO, AWAKE,
    DN_LC_ISO, DN_LC_PWR, DN_BC_ISO, DN_BC_PWR
  } state_e;
  // Reload values are N-1; a zero parameter collapses to a one-cycle step.
  localparam logic [7:0] DB_N  = 8'(DEBOUNCE_CYC > 1 ? DEBOUNCE_CYC - 1 : 0);
  localparam logic [7:0] BC_N  = 8'(BC_PWR_DLY > 1 ? BC_PWR_DLY - 1 : 0);
  localparam logic [7:0] ISO_N = 8'(ISO_DLY > 1 ? ISO_DLY - 1 : 0);
  localparam logic [7:0] LC_N  = 8'(LC_PWR_DLY > 1 ? LC_PWR_DLY - 1 : 0);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, load;
  logic sync1_q, sync2_q, done;
  logic bc_pwr_d, bc_iso_d, lc_pwr_d, lc_iso_d, clr_d, wake_d, busy_d;
  assign done = cnt_q == 8'd0;
  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      state_q        <= SLEEP;
      cnt_q          <= 8'd0;
      BC_PWR_ON      <= 1'b0;
      BC_RELEASE_ISO <= 1'b0;
      LC_PWR_ON      <= 1'b0;
      LC_RELEASE_ISO <= 1'b0;
      CLR_EXT_INT    <= 1'b0;
      WAKE_DONE      <= 1'b0;
      SEQ_BUSY       <= 1'b0;
    end else begin
      sync1_q        <= INT_REQ;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      BC_PWR_ON      <= bc_pwr_d;
      BC_RELEASE_ISO <= bc_iso_d;
      LC_PWR_ON      <= lc_pwr_d;
      LC_RELEASE_ISO <= lc_iso_d;
      CLR_EXT_INT    <= clr_d;
      WAKE_DONE      <= wake_d;
      SEQ_BUSY       <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLEEP:     state_d = sync2_q ? DEBOUNCE : SLEEP;
      DEBOUNCE:  state_d = !sync2_q ? SLEEP : done ? UP_BC_PWR : DEBOUNCE;
      UP_BC_PWR: state_d = done ? UP_BC_ISO : UP_BC_PWR;
      UP_BC_ISO: state_d = done ? UP_LC_PWR : UP_BC_ISO;
      UP_LC_PWR: state_d = done ? UP_LC_ISO : UP_LC_PWR;
      UP_LC_ISO: state_d = done ? AWAKE : UP_LC_ISO;
      AWAKE:     state_d = SLEEP_REQ ? DN_LC_ISO : AWAKE;
      DN_LC_ISO: state_d = done ? DN_LC_PWR : DN_LC_ISO;
      DN_LC_PWR: state_d = done ? DN_BC_ISO : DN_LC_PWR;
      DN_BC_ISO: state_d = done ? DN_BC_PWR : DN_BC_ISO;
      DN_BC_PWR: state_d = done ? SLEEP : DN_BC_PWR;
      default:   state_d = SLEEP;
    endcase
  end
  always_comb begin
    load = 8'd0;
    case (state_d)
      DEBOUNCE:             load = DB_N;
      UP_BC_PWR, DN_BC_PWR: load = BC_N;
      UP_LC_PWR, DN_LC_PWR: load = LC_N;
      UP_BC_ISO, UP_LC_ISO,
      DN_LC_ISO, DN_BC_ISO: load = ISO_N;
      default:              load = 8'd0;
    endcase
    cnt_d = (state_d != state_q) ? load : done ? cnt_q : cnt_q - 8'd1;
  end
  // Outputs are decoded from the next state so they switch on the transition edge.
  always_comb begin
    bc_pwr_d = state_d inside {UP_BC_PWR, UP_BC_ISO, UP_LC_PWR, UP_LC_ISO, AWAKE,
                               DN_LC_ISO, DN_LC_PWR, DN_BC_ISO};
    bc_iso_d = state_d inside {UP_BC_ISO, UP_LC_PWR, UP_LC_ISO, AWAKE, DN_LC_ISO, DN_LC_PWR};
    lc_pwr_d = state_d inside {UP_LC_PWR, UP_LC_ISO, AWAKE, DN_LC_ISO};
    lc_iso_d = state_d inside {UP_LC_ISO, AWAKE};
    clr_d    = state_d == AWAKE && state_q != AWAKE;
    wake_d   = state_d == AWAKE;
    busy_d   = !(state_d inside {SLEEP, AWAKE});
  end
endmodule

// File: tb/tb_mbus_wakeup_seq.sv
// tb_mbus_wakeup_seq: vectors, directed corners and random traffic against a power-level model.
module tb_mbus_wakeup_seq;
  localparam int M_IDLE = 0, M_DB = 1, M_UP = 2, M_AW = 3, M_DN = 4;
  logic clk = 1'b0, rst_n, int_req, slp;
  logic bp0, bi0, lp0, li0, cl0, wd0, sb0;
  logic bp1, bi1, lp1, li1, cl1, wd1, sb1;
  logic [6:0] o0, o1;
  int checks = 0, failures = 0;
  assign o0 = {bp0, bi0, lp0, li0, cl0, wd0, sb0};
  assign o1 = {bp1, bi1, lp1, li1, cl1, wd1, sb1};
  always #5 clk = ~clk;

  mbus_wakeup_seq dut0 (
    .CLKIN(clk), .RESETn(rst_n), .INT_REQ(int_req), .SLEEP_REQ(slp),
    .BC_PWR_ON(bp0), .BC_RELEASE_ISO(bi0), .LC_PWR_ON(lp0), .LC_RELEASE_ISO(li0),
    .CLR_EXT_INT(cl0), .WAKE_DONE(wd0), .SEQ_BUSY(sb0)
  );
  mbus_wakeup_seq #(.DEBOUNCE_CYC(1), .BC_PWR_DLY(0), .ISO_DLY(0), .LC_PWR_DLY(0)) dut1 (
    .CLKIN(clk), .RESETn(rst_n), .INT_REQ(int_req), .SLEEP_REQ(slp),
    .BC_PWR_ON(bp1), .BC_RELEASE_ISO(bi1), .LC_PWR_ON(lp1), .LC_RELEASE_ISO(li1),
    .CLR_EXT_INT(cl1), .WAKE_DONE(wd1), .SEQ_BUSY(sb1)
  );

  // Model: a power level 0..4 climbed or descended one step per hold time.
  int dly[2][5] = '{'{0, 8, 2, 8, 2}, '{0, 1, 1, 1, 1}};
  int dbn[2] = '{4, 1};
  int m_mode[2], m_l[2], m_t[2];
  bit m_first[2], m_sh0, m_sh1;

  task automatic chk(input string n, input logic [6:0] a, input logic [6:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask

  function automatic logic [6:0] m_out(input int k);
    int lvl;
    lvl = (m_mode[k] inside {M_UP, M_AW, M_DN}) ? m_l[k] : 0;
    return {lvl >= 1, lvl >= 2, lvl >= 3, lvl >= 4, m_mode[k] == M_AW && m_first[k],
            m_mode[k] == M_AW, m_mode[k] inside {M_DB, M_UP, M_DN}};
  endfunction

  task automatic step(input int k, input bit s);
    case (m_mode[k])
      M_IDLE: if (s) begin m_mode[k] = M_DB; m_t[k] = dbn[k]; end
      M_DB: if (!s) m_mode[k] = M_IDLE;
            else begin
              m_t[k]--;
              if (m_t[k] == 0) begin m_mode[k] = M_UP; m_l[k] = 1; m_t[k] = dly[k][1]; end
            end
      M_UP: begin
        m_t[k]--;
        if (m_t[k] == 0) begin
          if (m_l[k] == 4) begin m_mode[k] = M_AW; m_first[k] = 1; end
          else begin m_l[k]++; m_t[k] = dly[k][m_l[k]]; end
        end
      end
      M_AW: begin
        m_first[k] = 0;
        if (slp) begin m_mode[k] = M_DN; m_l[k] = 3; m_t[k] = dly[k][4]; end
      end
      M_DN: begin
        m_t[k]--;
        if (m_t[k] == 0) begin
          if (m_l[k] == 0) m_mode[k] = M_IDLE;
          else begin m_l[k]--; m_t[k] = dly[k][m_l[k] + 1]; end
        end
      end
      default: m_mode[k] = M_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin m_mode[k] = M_IDLE; m_l[k] = 0; m_t[k] = 0; m_first[k] = 0; end
      m_sh0 = 0; m_sh1 = 0;
    end else begin
      for (int k = 0; k < 2; k++) step(k, m_sh1);
      m_sh1 = m_sh0;
      m_sh0 = int_req;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_dflt", o0, m_out(0));
    chk("model_fast", o1, m_out(1));
    chk("invariant_dflt", 7'((!bi0 || bp0) && (!lp0 || bi0) && (!li0 || lp0)), 7'd1);
    chk("invariant_fast", 7'((!bi1 || bp1) && (!lp1 || bi1) && (!li1 || lp1)), 7'd1);
  end

  typedef struct {bit i; bit s; int n; logic [6:0] e;} vec_t;
  vec_t tbl[$];
  int clr_n, wake_n, hold;

  initial begin
    // {int, sleep, edges, {bc_pwr, bc_iso, lc_pwr, lc_iso, clr, wake, busy}}
    tbl.push_back('{1, 0, 6, 7'b0000001}); tbl.push_back('{1, 0, 1, 7'b1000001});
    tbl.push_back('{1, 0, 7, 7'b1000001}); tbl.push_back('{1, 0, 1, 7'b1100001});
    tbl.push_back('{1, 0, 1, 7'b1100001}); tbl.push_back('{1, 0, 1, 7'b1110001});
    tbl.push_back('{1, 0, 7, 7'b1110001}); tbl.push_back('{1, 0, 1, 7'b1111001});
    tbl.push_back('{1, 0, 1, 7'b1111001}); tbl.push_back('{1, 0, 1, 7'b1111110});
    tbl.push_back('{0, 0, 1, 7'b1111010}); tbl.push_back('{1, 0, 3, 7'b1111010});
    tbl.push_back('{0, 0, 3, 7'b1111010});
    tbl.push_back('{0, 1, 1, 7'b1110001}); tbl.push_back('{0, 0, 1, 7'b1110001});
    tbl.push_back('{0, 0, 1, 7'b1100001}); tbl.push_back('{0, 0, 7, 7'b1100001});
    tbl.push_back('{0, 0, 1, 7'b1000001}); tbl.push_back('{0, 0, 1, 7'b1000001});
    tbl.push_back('{0, 0, 1, 7'b0000001}); tbl.push_back('{0, 0, 7, 7'b0000001});
    tbl.push_back('{0, 0, 1, 7'b0000000});
    tbl.push_back('{1, 0, 3, 7'b0000001}); tbl.push_back('{0, 0, 1, 7'b0000001});
    tbl.push_back('{1, 0, 1, 7'b0000001}); tbl.push_back('{1, 0, 1, 7'b0000000});
    tbl.push_back('{1, 0, 1, 7'b0000001}); tbl.push_back('{0, 0, 2, 7'b0000001});
    tbl.push_back('{0, 0, 1, 7'b0000000}); tbl.push_back('{0, 0, 3, 7'b0000000});

    rst_n = 1'b0; int_req = 1'b0; slp = 1'b0;
    repeat (3) @(negedge clk);
    int_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_hold", o0, 7'd0);
    end
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      int_req = tbl[i].i;
      slp = tbl[i].s;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), o0, tbl[i].e);
    end

    int_req = 1'b1;
    for (int c = 0; c < 60 && !lp0; c++) @(negedge clk);
    chk("reach_lc_pwr", 7'(lp0), 7'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_dflt", o0, 7'd0);
    chk("async_rst_fast", o1, 7'd0);
    @(negedge clk);
    int_req = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("stay_sleep", o0, 7'd0);

    int_req = 1'b1; slp = 1'b1;
    clr_n = 0; wake_n = 0;
    repeat (150) begin
      @(negedge clk);
      clr_n += int'(cl0);
      wake_n += int'(wd0);
    end
    chk("rewake_count", 7'(clr_n >= 2), 7'd1);
    chk("one_awake_cycle", 7'(wake_n), 7'(clr_n));
    int_req = 1'b0; slp = 1'b0;
    repeat (40) @(negedge clk);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        int_req = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 30);
      end
      hold--;
      slp = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mbus_wakeup_seq.md
# mbus_wakeup_seq

Mediator-side responder to the node interrupt request: watches the bus-level external-interrupt line, debounces it, and sequences a sleeping layer back to life. The order is bus-controller power, bus-controller isolation release, layer-controller power, then layer-controller isolation release. It then pulses an interrupt-clear back toward the requester and reports awake. On a sleep request it runs the same sequence in reverse. It sits between the bus wire front end and the power-gate and isolation cells of one layer.

## Interface
- DEBOUNCE_CYC, 4: consecutive synchronized-high cycles required to accept an interrupt (1..255).
- BC_PWR_DLY, 8: cycles held in each bus-controller power step (1..255).
- ISO_DLY, 2: cycles held in each isolation step (1..255).
- LC_PWR_DLY, 8: cycles held in each layer-controller power step (1..255).
- Parameter value 0 behaves as 1. Step counter is 8 bits.

Ports:
- CLKIN, in, 1: sole clock, rising edge.
- RESETn, in, 1: asynchronous active-low reset.
- INT_REQ, in, 1: external interrupt from bus wire, asynchronous, active high.
- SLEEP_REQ, in, 1: level request to power down; sampled only in AWAKE.
- BC_PWR_ON, out, 1: bus-controller power enable.
- BC_RELEASE_ISO, out, 1: bus-controller isolation release (1 = released).
- LC_PWR_ON, out, 1: layer-controller power enable.
- LC_RELEASE_ISO, out, 1: layer-controller isolation release.
- CLR_EXT_INT, out, 1: one-cycle pulse clearing the requester's interrupt.
- WAKE_DONE, out, 1: high while in AWAKE.
- SEQ_BUSY, out, 1: high in any state other than SLEEP or AWAKE.

## Operation
- INT_REQ passes through a 2-flop synchronizer to give INT_SYNC. All outputs are registered.
- States: SLEEP, DEBOUNCE, UP_BC_PWR, UP_BC_ISO, UP_LC_PWR, UP_LC_ISO, AWAKE, DN_LC_ISO, DN_LC_PWR, DN_BC_ISO, DN_BC_PWR.
- SLEEP: all outputs 0. INT_SYNC=1 moves to DEBOUNCE.
- DEBOUNCE: counts INT_SYNC-high cycles.
  - INT_SYNC=0 returns to SLEEP.
  - DEBOUNCE_CYC consecutive highs move to UP_BC_PWR.
- UP_BC_PWR: BC_PWR_ON=1; hold BC_PWR_DLY cycles, then UP_BC_ISO.
- UP_BC_ISO: BC_RELEASE_ISO=1; hold ISO_DLY cycles, then UP_LC_PWR.
- UP_LC_PWR: LC_PWR_ON=1; hold LC_PWR_DLY cycles, then UP_LC_ISO.
- UP_LC_ISO: LC_RELEASE_ISO=1; hold ISO_DLY cycles, then AWAKE.
- AWAKE: WAKE_DONE=1; CLR_EXT_INT=1 in the first AWAKE cycle only. SLEEP_REQ=1 moves to DN_LC_ISO.
- DN_LC_ISO: LC_RELEASE_ISO=0; hold ISO_DLY cycles, then DN_LC_PWR.
- DN_LC_PWR: LC_PWR_ON=0; hold LC_PWR_DLY cycles, then DN_BC_ISO.
- DN_BC_ISO: BC_RELEASE_ISO=0; hold ISO_DLY cycles, then DN_BC_PWR.
- DN_BC_PWR: BC_PWR_ON=0; hold BC_PWR_DLY cycles, then SLEEP.
- Invariants, always:
  - BC_RELEASE_ISO=1 implies BC_PWR_ON=1.
  - LC_PWR_ON=1 implies BC_RELEASE_ISO=1.
  - LC_RELEASE_ISO=1 implies LC_PWR_ON=1.
- Sequences are non-abortable:
  - SLEEP_REQ during power-up is ignored. If still high on reaching AWAKE, shutdown starts the cycle after the CLR_EXT_INT pulse.
  - INT_REQ during power-down is ignored. If INT_SYNC is high in SLEEP, debounce restarts immediately.
- INT_REQ in AWAKE has no effect; no second CLR_EXT_INT is issued.

## Timing
- Reset, asynchronous: state SLEEP, synchronizer and counter cleared, every output 0.
  - Reset mid-sequence forces all outputs to 0 in the same instant, ignoring sequencing.
  - Deassertion resumes in SLEEP.
- Wait counter:
  - Loads N-1 on state entry and decrements.
  - The transition happens on the edge where the count is 0, so each step lasts exactly N cycles.
  - The next step's output changes on that same edge.
- Wake latency, from the first edge sampling INT_REQ=1 to BC_PWR_ON=1: 2 + 1 + DEBOUNCE_CYC edges.
  - Default: 7 edges.
- BC_PWR_ON rise to AWAKE: BC_PWR_DLY + ISO_DLY + LC_PWR_DLY + ISO_DLY cycles.
  - Default: 20 cycles.
  - CLR_EXT_INT and WAKE_DONE rise on the same edge.
- AWAKE with SLEEP_REQ=1 to all outputs 0: ISO_DLY + LC_PWR_DLY + ISO_DLY + 1 cycles to BC_PWR_ON falling, then BC_PWR_DLY more cycles before SLEEP.
- SEQ_BUSY is registered with the state and is 1 exactly in DEBOUNCE, UP_*, and DN_* states.

## Test plan
- Reset, then hold RESETn=0 with INT_REQ=1: all outputs stay 0. Release and hold INT_REQ=1 (defaults):
  - BC_PWR_ON rises 7 edges later.
  - BC_RELEASE_ISO rises 8 cycles after that, LC_PWR_ON 2 later, LC_RELEASE_ISO 8 later.
  - 2 cycles later WAKE_DONE rises and CLR_EXT_INT pulses for exactly 1 cycle.
- Glitch filter: INT_REQ high 3 cycles, low 1, high 3.
  - Response: BC_PWR_ON never rises; SEQ_BUSY toggles; FSM returns to SLEEP.
- Shutdown: in AWAKE, pulse SLEEP_REQ for 1 cycle.
  - LC_RELEASE_ISO falls first, then LC_PWR_ON 2 cycles later, BC_RELEASE_ISO 8 later, BC_PWR_ON 2 later.
  - SLEEP is reached 8 cycles after BC_PWR_ON falls, with WAKE_DONE=0 throughout.
- Simultaneous events:
  - SLEEP_REQ=1 held during the whole power-up gives full power-up, one CLR_EXT_INT pulse, one AWAKE cycle, then shutdown.
  - INT_REQ=1 held during shutdown causes an immediate re-debounce after SLEEP, with a second wake completing.
- Reset mid-sequence: assert RESETn=0 while in UP_LC_PWR.
  - All outputs go to 0 asynchronously.
  - After release with INT_REQ=0 the FSM stays in SLEEP.
- Parameter corners: DEBOUNCE_CYC=1 and all delays 0.
  - Each step lasts 1 cycle.
  - The invariants are checked every cycle by assertion.
